// File: rtl/zigzag_buffer_if.sv
// Coefficient stream bundle for zigzag_buffer: raster-order input side and zigzag-order output side.
// slave is the buffer's view; master is the view of the quantizer/entropy-coder pair around it.
interface zigzag_buffer_if #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 12
);
    logic                    ena_in;
    logic                    rdy_out;
    logic signed [IN_W-1:0]  in;
    logic                    rdy_in;
    logic                    ena_out;
    logic signed [OUT_W-1:0] out;
    logic                    out_first;
    logic                    out_last;

    modport master (
        output ena_in, in, rdy_in,
        input  rdy_out, ena_out, out, out_first, out_last
    );

    modport slave (
        input  ena_in, in, rdy_in,
        output rdy_out, ena_out, out, out_first, out_last
    );
endinterface

// File: rtl/zigzag_buffer.sv
// Two-bank ping-pong buffer: 8x8 blocks written in raster order, re-emitted in JPEG zigzag order.
// Define DC_DIFF_EN to emit the DC term as the difference from the previous block's DC.
module zigzag_buffer #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 12
) (
    input logic            clk,
    input logic            rst,
    zigzag_buffer_if.slave bus
);
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10, 6'd17, 6'd24, 6'd32, 6'd25, 6'd18,
        6'd11, 6'd4,  6'd5,  6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd27, 6'd20,
        6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28, 6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43,
        6'd36, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51, 6'd58, 6'd59, 6'd52, 6'd45,
        6'd38, 6'd31, 6'd39, 6'd46, 6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [IN_W-1:0]         mem [0:127];
    logic                    wr_bank;
    logic                    rd_bank;
    logic [5:0]              wr_idx;
    logic [5:0]              rd_pos;
    logic [1:0]              full;
    logic [1:0]              full_next;
    logic                    accept;
    logic                    xfer;
    logic [IN_W-1:0]         rd_raw;
    logic signed [OUT_W-1:0] rd_ext;

    assign accept        = bus.ena_in && bus.rdy_out;
    assign xfer          = bus.ena_out;
    assign bus.rdy_out   = !full[wr_bank];
    assign bus.ena_out   = bus.rdy_in && full[rd_bank];
    assign bus.out_first = (rd_pos == 6'd0);
    assign bus.out_last  = (rd_pos == 6'd63);

    assign rd_raw = mem[{rd_bank, ZZ[rd_pos]}];
    assign rd_ext = {{(OUT_W-IN_W){rd_raw[IN_W-1]}}, rd_raw};

    // NOTE: the storage array is deliberately not reset; the full flags decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) mem[{wr_bank, wr_idx}] <= bus.in;
    end

    // Fill and drain always target different banks, so both updates can land in one cycle.
    always_comb begin
        // NOTE: default assignment first so no path leaves full_next unassigned (no latch).
        full_next = full;
        if (accept && wr_idx == 6'd63) full_next[wr_bank] = 1'b1;
        if (xfer && rd_pos == 6'd63)   full_next[rd_bank] = 1'b0;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= 6'd0;
            rd_pos  <= 6'd0;
            full    <= 2'b00;
        end else begin
            if (accept) begin
                wr_idx <= wr_idx + 6'd1;
                if (wr_idx == 6'd63) wr_bank <= ~wr_bank;
            end
            if (xfer) begin
                rd_pos <= rd_pos + 6'd1;
                if (rd_pos == 6'd63) rd_bank <= ~rd_bank;
            end
            full <= full_next;
        end
    end

`ifdef DC_DIFF_EN
    logic [IN_W-1:0]         pred;
    logic signed [OUT_W-1:0] pred_ext;

    assign pred_ext = {{(OUT_W-IN_W){pred[IN_W-1]}}, pred};

    always_ff @(posedge clk) begin
        if (rst)                           pred <= '0;
        else if (xfer && rd_pos == 6'd0)   pred <= rd_raw;
    end

    // One extra bit of headroom makes the DC difference exact.
    assign bus.out = (rd_pos == 6'd0) ? rd_ext - pred_ext : rd_ext;
`else
    assign bus.out = rd_ext;
`endif
endmodule

// File: tb/tb_zigzag_buffer.sv
// Self-checking bench for zigzag_buffer against a queue-based zigzag reference model.
// Expected DC values follow DC_DIFF_EN when it is defined for the build.
module tb_zigzag_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zigzag_buffer_if #(.IN_W(11), .OUT_W(12)) bus ();
    zigzag_buffer #(.IN_W(11), .OUT_W(12)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic signed [11:0] val;
        logic               is_first;
        logic               is_last;
    } exp_t;

    exp_t               exp_q[$];
    exp_t               exp_now;
    bit                 have_exp;
    logic signed [10:0] blk [64];
    int                 blk_cnt;
    logic signed [10:0] pred_m;
    int                 zz_ord [64];
    int                 checks;
    int                 errors;

    logic               o_rdy, o_ena, o_first, o_last;
    logic signed [11:0] o_out;
    logic               exp_rdy, exp_ena;

    // Zigzag order derived from the anti-diagonal walk, not copied from a table.
    function automatic void build_zz();
        int p = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 8) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz_ord[p] = r * 8 + (s - r); p++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz_ord[p] = r * 8 + (s - r); p++; end
            end
        end
    endfunction

    function automatic logic signed [10:0] rnd_coef();
        if ($urandom_range(0, 15) == 0) return 11'h400;
        return 11'($urandom_range(0, 2047));
    endfunction

    function automatic void model_write(input logic signed [10:0] d);
        exp_t e;
        blk[blk_cnt] = d;
        blk_cnt++;
        if (blk_cnt == 64) begin
            for (int p = 0; p < 64; p++) begin
                e.val = blk[zz_ord[p]];
`ifdef DC_DIFF_EN
                if (p == 0) begin
                    e.val  = blk[0] - pred_m;
                    pred_m = blk[0];
                end
`endif
                e.is_first = (p == 0);
                e.is_last  = (p == 63);
                exp_q.push_back(e);
            end
            blk_cnt = 0;
        end
    endfunction

    // Drives one cycle, samples outputs before the next rising edge and advances the model.
    task automatic cycle(input bit e, input logic signed [10:0] d, input bit r);
        @(negedge clk);
        bus.ena_in = e;
        bus.in     = d;
        bus.rdy_in = r;
        #1;
        o_rdy   = bus.rdy_out;
        o_ena   = bus.ena_out;
        o_out   = bus.out;
        o_first = bus.out_first;
        o_last  = bus.out_last;
        exp_rdy = (exp_q.size() <= 64);
        exp_ena = r && (exp_q.size() > 0);
        have_exp = 1'b0;
        if (o_ena && exp_q.size() > 0) begin
            exp_now  = exp_q.pop_front();
            have_exp = 1'b1;
        end
        if (e && o_rdy) model_write(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        bus.ena_in = 1'b0;
        bus.rdy_in = 1'b0;
        bus.in     = '0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        blk_cnt = 0;
        pred_m  = '0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.rdy_in = 1'b1;
        #1;
        checks += 4;
        if (bus.rdy_out !== 1'b1)   begin errors++; $display("FAIL reset rdy_out got %b want 1", bus.rdy_out); end
        if (bus.ena_out !== 1'b0)   begin errors++; $display("FAIL reset ena_out got %b want 0", bus.ena_out); end
        if (bus.out_first !== 1'b1) begin errors++; $display("FAIL reset out_first got %b want 1", bus.out_first); end
        if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL reset out_last got %b want 0", bus.out_last); end
    endtask

    task automatic test_ramp();
        int n = 0;
        int t = 0;
        for (int k = 0; k < 64; k++) begin
            cycle(1'b1, 11'(k), 1'b1);
            checks += 2;
            if (o_rdy !== 1'b1) begin errors++; $display("FAIL ramp rdy_out at write %0d got %b want 1", k, o_rdy); end
            if (o_ena !== 1'b0) begin errors++; $display("FAIL ramp early ena_out at write %0d got %b want 0", k, o_ena); end
        end
        while (n < 64 && t < 200) begin
            cycle(1'b0, '0, 1'b1);
            t++;
            if (t == 1) begin
                checks++;
                if (o_ena !== 1'b1) begin errors++; $display("FAIL ramp latency ena_out got %b want 1", o_ena); end
            end
            if (o_ena) begin
                checks++;
                if (o_out !== 12'(zz_ord[n]) || o_first !== (n == 0) || o_last !== (n == 63)) begin
                    errors++;
                    $display("FAIL ramp pos %0d got %0d f%b l%b want %0d f%b l%b",
                             n, o_out, o_first, o_last, zz_ord[n], (n == 0), (n == 63));
                end
                if (n == 6 || n == 35) begin
                    checks++;
                    if (o_out !== ((n == 6) ? 12'sd3 : 12'sd56)) begin
                        errors++; $display("FAIL ramp table pos %0d got %0d", n, o_out);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 64) begin errors++; $display("FAIL ramp timeout got %0d outputs want 64", n); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, t = 0;
        bit started = 1'b0;
        while ((sent < 192 || got < 192) && t < 600) begin
            if (sent < 192) cycle(1'b1, rnd_coef(), 1'b1);
            else            cycle(1'b0, '0, 1'b1);
            t++;
            if (sent < 192) begin
                checks++;
                if (o_rdy !== 1'b1) begin errors++; $display("FAIL b2b rdy_out dropped at write %0d", sent); end
                if (o_rdy) sent++;
            end
            checks += 2;
            if (o_rdy !== exp_rdy) begin errors++; $display("FAIL b2b rdy_out got %b want %b", o_rdy, exp_rdy); end
            if (o_ena !== exp_ena) begin errors++; $display("FAIL b2b ena_out got %b want %b", o_ena, exp_ena); end
            if (have_exp) begin
                checks++;
                if (o_out !== exp_now.val || o_first !== exp_now.is_first || o_last !== exp_now.is_last) begin
                    errors++;
                    $display("FAIL b2b data got %0d f%b l%b want %0d f%b l%b",
                             o_out, o_first, o_last, exp_now.val, exp_now.is_first, exp_now.is_last);
                end
            end
            if (started && got < 192) begin
                checks++;
                if (!o_ena) begin errors++; $display("FAIL b2b gap after %0d outputs got ena_out 0 want 1", got); end
            end
            if (o_ena) begin started = 1'b1; got++; end
        end
        checks++;
        if (got != 192) begin errors++; $display("FAIL b2b timeout got %0d outputs want 192", got); end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, t = 0;
        while (sent < 128 && t < 400) begin
            cycle(1'b1, rnd_coef(), 1'b0);
            t++;
            checks += 2;
            if (o_rdy !== exp_rdy) begin errors++; $display("FAIL bp fill rdy_out got %b want %b", o_rdy, exp_rdy); end
            if (o_ena !== 1'b0)    begin errors++; $display("FAIL bp fill ena_out got %b want 0", o_ena); end
            if (o_rdy) sent++;
        end
        cycle(1'b1, rnd_coef(), 1'b0);
        checks += 2;
        if (o_rdy !== 1'b0) begin errors++; $display("FAIL bp rdy_out after 128 accepts got %b want 0", o_rdy); end
        if (o_ena !== 1'b0) begin errors++; $display("FAIL bp ena_out while held got %b want 0", o_ena); end
        t = 0;
        while (got < 128 && t < 400) begin
            cycle(1'b0, '0, 1'b1);
            t++;
            checks += 2;
            if (o_rdy !== exp_rdy) begin errors++; $display("FAIL bp drain rdy_out got %b want %b", o_rdy, exp_rdy); end
            if (o_ena !== exp_ena) begin errors++; $display("FAIL bp drain ena_out got %b want %b", o_ena, exp_ena); end
            if (have_exp) begin
                checks++;
                if (o_out !== exp_now.val || o_first !== exp_now.is_first || o_last !== exp_now.is_last) begin
                    errors++;
                    $display("FAIL bp data got %0d f%b l%b want %0d f%b l%b",
                             o_out, o_first, o_last, exp_now.val, exp_now.is_first, exp_now.is_last);
                end
            end
            if (o_ena) got++;
        end
        checks++;
        if (got != 128) begin errors++; $display("FAIL bp timeout got %0d outputs want 128", got); end
    endtask

    task automatic test_random();
        int sent = 0, got = 0, t = 0;
        while ((sent < 1280 || got < 1280) && t < 12000) begin
            bit e = (sent < 1280) && ($urandom_range(0, 3) != 0);
            bit r = ($urandom_range(0, 2) != 0);
            cycle(e, rnd_coef(), r);
            t++;
            checks += 2;
            if (o_rdy !== exp_rdy) begin errors++; $display("FAIL rnd rdy_out got %b want %b", o_rdy, exp_rdy); end
            if (o_ena !== exp_ena) begin errors++; $display("FAIL rnd ena_out got %b want %b", o_ena, exp_ena); end
            if (have_exp) begin
                checks++;
                if (o_out !== exp_now.val || o_first !== exp_now.is_first || o_last !== exp_now.is_last) begin
                    errors++;
                    $display("FAIL rnd data got %0d f%b l%b want %0d f%b l%b",
                             o_out, o_first, o_last, exp_now.val, exp_now.is_first, exp_now.is_last);
                end
            end
            if (e && o_rdy) sent++;
            if (o_ena) got++;
        end
        checks++;
        if (got != 1280) begin errors++; $display("FAIL rnd timeout got %0d outputs want 1280", got); end
    endtask

    task automatic test_mid_reset();
        int sent = 0, got = 0, t = 0;
        for (int k = 0; k < 30; k++) cycle(1'b1, rnd_coef(), 1'b1);
        do_reset();
        cycle(1'b0, '0, 1'b1);
        checks += 2;
        if (o_rdy !== 1'b1) begin errors++; $display("FAIL mid_reset rdy_out got %b want 1", o_rdy); end
        if (o_ena !== 1'b0) begin errors++; $display("FAIL mid_reset ena_out got %b want 0", o_ena); end
        while ((sent < 64 || got < 64) && t < 300) begin
            if (sent < 64) cycle(1'b1, rnd_coef(), 1'b1);
            else           cycle(1'b0, '0, 1'b1);
            t++;
            checks += 2;
            if (o_rdy !== exp_rdy) begin errors++; $display("FAIL mid_reset rdy_out got %b want %b", o_rdy, exp_rdy); end
            if (o_ena !== exp_ena) begin errors++; $display("FAIL mid_reset ena_out got %b want %b", o_ena, exp_ena); end
            if (have_exp) begin
                checks++;
                if (o_out !== exp_now.val || o_first !== exp_now.is_first || o_last !== exp_now.is_last) begin
                    errors++;
                    $display("FAIL mid_reset data got %0d f%b l%b want %0d f%b l%b",
                             o_out, o_first, o_last, exp_now.val, exp_now.is_first, exp_now.is_last);
                end
            end
            if (sent < 64 && o_rdy) sent++;
            if (o_ena) got++;
        end
        checks++;
        if (got != 64) begin errors++; $display("FAIL mid_reset timeout got %0d outputs want 64", got); end
    endtask

    task automatic test_dc();
        logic signed [10:0] dcs [3];
        logic signed [11:0] dc_want [3];
        logic signed [10:0] d;
        int sent = 0, got = 0, t = 0;
        dcs = '{11'sd100, 11'sd90, 11'h400};
`ifdef DC_DIFF_EN
        dc_want = '{12'sd100, -12'sd10, -12'sd1114};
`else
        dc_want = '{12'sd100, 12'sd90, -12'sd1024};
`endif
        do_reset();
        while ((sent < 192 || got < 192) && t < 600) begin
            if (sent % 64 == 0)  d = dcs[sent / 64];
            else if (sent == 1)  d = 11'h400;
            else                 d = rnd_coef();
            if (sent < 192) cycle(1'b1, d, 1'b1);
            else            cycle(1'b0, '0, 1'b1);
            t++;
            checks += 2;
            if (o_rdy !== exp_rdy) begin errors++; $display("FAIL dc rdy_out got %b want %b", o_rdy, exp_rdy); end
            if (o_ena !== exp_ena) begin errors++; $display("FAIL dc ena_out got %b want %b", o_ena, exp_ena); end
            if (have_exp) begin
                checks++;
                if (o_out !== exp_now.val || o_first !== exp_now.is_first || o_last !== exp_now.is_last) begin
                    errors++;
                    $display("FAIL dc data got %0d f%b l%b want %0d f%b l%b",
                             o_out, o_first, o_last, exp_now.val, exp_now.is_first, exp_now.is_last);
                end
            end
            if (o_ena && o_first && got < 192) begin
                checks++;
                if (o_out !== dc_want[got / 64]) begin
                    errors++; $display("FAIL dc block %0d got %0d want %0d", got / 64, o_out, dc_want[got / 64]);
                end
            end
            if (o_ena && got == 1) begin
                checks++;
                if (o_out !== 12'hC00) begin errors++; $display("FAIL dc sign_ext got %h want c00", o_out); end
            end
            if (sent < 192 && o_rdy) sent++;
            if (o_ena) got++;
        end
        checks++;
        if (got != 192) begin errors++; $display("FAIL dc timeout got %0d outputs want 192", got); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        blk_cnt    = 0;
        pred_m     = '0;
        bus.ena_in = 1'b0;
        bus.rdy_in = 1'b0;
        bus.in     = '0;
        build_zz();
        test_reset();
        test_ramp();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_dc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
